// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS control unit and its datapath.
// The master side is the control unit. The slave side is the datapath, which returns instruction fields and the ALU zero flag.
interface multicycle_control_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcEn;
  logic       iorD;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] pcSrc;
  logic [2:0] aluControl;
  logic       illegalOp;

  modport master (
    input  op, funct, zero,
    output pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite,
           aluSrcA, aluSrcB, pcSrc, aluControl, illegalOp
  );

  modport slave (
    output op, funct, zero,
    input  pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite,
           aluSrcA, aluSrcB, pcSrc, aluControl, illegalOp
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath.
// It sequences each instruction and drives the datapath enables, the mux selects and the ALU operation.
module multicycle_control (
  input  logic                        clk,
  input  logic                        rstN,
  multicycle_control_if.master        bus
);

  localparam int unsigned OpW  = 6;
  localparam int unsigned AluW = 3;

  localparam logic [OpW-1:0] OpRtype = 6'b000000;
  localparam logic [OpW-1:0] OpLw    = 6'b100011;
  localparam logic [OpW-1:0] OpSw    = 6'b101011;
  localparam logic [OpW-1:0] OpBeq   = 6'b000100;
  localparam logic [OpW-1:0] OpAddi  = 6'b001000;
  localparam logic [OpW-1:0] OpJ     = 6'b000010;

  localparam logic [OpW-1:0] FnAdd = 6'b100000;
  localparam logic [OpW-1:0] FnSub = 6'b100010;
  localparam logic [OpW-1:0] FnAnd = 6'b100100;
  localparam logic [OpW-1:0] FnOr  = 6'b100101;
  localparam logic [OpW-1:0] FnSlt = 6'b101010;

  localparam logic [AluW-1:0] AluAdd = 3'b010;
  localparam logic [AluW-1:0] AluSub = 3'b110;
  localparam logic [AluW-1:0] AluAnd = 3'b000;
  localparam logic [AluW-1:0] AluOr  = 3'b001;
  localparam logic [AluW-1:0] AluSlt = 3'b111;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } stateT;

  stateT state;
  stateT stateNext;

  logic            pcWrite;
  logic            branch;
  logic            irWriteRaw;
  logic            memWriteRaw;
  logic            regWriteRaw;
  logic            functLegal;
  logic            opLegal;
  logic [AluW-1:0] functAlu;

  // R-type function decode; an unsupported funct makes the instruction illegal
  always_comb begin
    functLegal = 1'b1;
    functAlu   = AluAdd;
    case (bus.funct)
      FnAdd:   functAlu = AluAdd;
      FnSub:   functAlu = AluSub;
      FnAnd:   functAlu = AluAnd;
      FnOr:    functAlu = AluOr;
      FnSlt:   functAlu = AluSlt;
      default: functLegal = 1'b0;
    endcase
  end

  always_comb begin
    opLegal = 1'b0;
    case (bus.op)
      OpRtype:                         opLegal = functLegal;
      OpLw, OpSw, OpBeq, OpAddi, OpJ:  opLegal = 1'b1;
      default:                         opLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state <= FETCH;
    else       state <= stateNext;
  end

  // Next state and Moore outputs; unused encodings fall back to FETCH with every enable low
  always_comb begin
    stateNext       = FETCH;
    pcWrite         = 1'b0;
    branch          = 1'b0;
    irWriteRaw      = 1'b0;
    memWriteRaw     = 1'b0;
    regWriteRaw     = 1'b0;
    bus.iorD        = 1'b0;
    bus.regDst      = 1'b0;
    bus.memToReg    = 1'b0;
    bus.aluSrcA     = 1'b0;
    bus.aluSrcB     = 2'b00;
    bus.pcSrc       = 2'b00;
    bus.aluControl  = AluAdd;
    case (state)
      FETCH: begin
        stateNext   = DECODE;
        irWriteRaw  = 1'b1;
        pcWrite     = 1'b1;
        bus.aluSrcB = 2'b01;
      end
      DECODE: begin
        bus.aluSrcB = 2'b11;
        if (opLegal) begin
          case (bus.op)
            OpLw, OpSw: stateNext = MEMADR;
            OpRtype:    stateNext = EXECUTE;
            OpBeq:      stateNext = BRANCH;
            OpAddi:     stateNext = ADDIEXEC;
            OpJ:        stateNext = JUMP;
            default:    stateNext = FETCH;
          endcase
        end
      end
      MEMADR: begin
        stateNext   = (bus.op == OpLw) ? MEMRD : MEMWR;
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
      end
      MEMRD: begin
        stateNext = MEMWB;
        bus.iorD  = 1'b1;
      end
      MEMWB: begin
        regWriteRaw  = 1'b1;
        bus.memToReg = 1'b1;
      end
      MEMWR: begin
        bus.iorD    = 1'b1;
        memWriteRaw = 1'b1;
      end
      EXECUTE: begin
        stateNext      = ALUWB;
        bus.aluSrcA    = 1'b1;
        bus.aluControl = functAlu;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
        bus.regDst  = 1'b1;
      end
      BRANCH: begin
        bus.aluSrcA    = 1'b1;
        bus.aluControl = AluSub;
        bus.pcSrc      = 2'b01;
        branch         = 1'b1;
      end
      ADDIEXEC: begin
        stateNext   = ADDIWB;
        bus.aluSrcA = 1'b1;
        bus.aluSrcB = 2'b10;
      end
      ADDIWB: begin
        regWriteRaw = 1'b1;
      end
      JUMP: begin
        bus.pcSrc = 2'b10;
        pcWrite   = 1'b1;
      end
      default: stateNext = FETCH;
    endcase
  end

  // Write enables are gated by reset so that an aborted instruction commits nothing in that cycle
  assign bus.pcEn      = rstN & (pcWrite | (branch & bus.zero));
  assign bus.irWrite   = rstN & irWriteRaw;
  assign bus.memWrite  = rstN & memWriteRaw;
  assign bus.regWrite  = rstN & regWriteRaw;
  assign bus.illegalOp = (state == DECODE) & ~opLegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control.
// It checks the whole control vector every cycle against hand-derived per-state values.
module tb_multicycle_control;

  logic clk;
  logic rstN;
  int   total = 0;
  int   bad   = 0;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {pcEn,iorD,memWrite,irWrite,regDst,memToReg,regWrite,aluSrcA,aluSrcB,pcSrc,aluControl,illegalOp}
  logic [15:0] obs;
  assign obs = {bus.pcEn, bus.iorD, bus.memWrite, bus.irWrite, bus.regDst, bus.memToReg,
                bus.regWrite, bus.aluSrcA, bus.aluSrcB, bus.pcSrc, bus.aluControl, bus.illegalOp};

  localparam logic [15:0] E_RST    = {8'b0000_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_FETCH  = {8'b1001_0000, 2'b01, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_DEC    = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_ILL    = {8'b0000_0000, 2'b11, 2'b00, 3'b010, 1'b1};
  localparam logic [15:0] E_ADR    = {8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMRD  = {8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMWB  = {8'b0000_0110, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_MEMWR  = {8'b0110_0000, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_ALUWB  = {8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_ADDIWB = {8'b0000_0010, 2'b00, 2'b00, 3'b010, 1'b0};
  localparam logic [15:0] E_JUMP   = {8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0};

  function automatic logic [15:0] eExec(input logic [2:0] alu);
    return {8'b0000_0001, 2'b00, 2'b00, alu, 1'b0};
  endfunction

  function automatic logic [15:0] eBranch(input logic z);
    return {z, 7'b000_0001, 2'b00, 2'b01, 3'b110, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [15:0] exp);
    #1;
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic nxt(input string tag, input logic [15:0] exp);
    @(negedge clk);
    chk(tag, exp);
  endtask

  initial begin
    rstN     = 1'b0;
    bus.op    = 6'b100011;
    bus.funct = 6'b000000;
    bus.zero  = 1'b0;

    repeat (3) begin
      @(negedge clk);
      chk("reset_hold", E_RST);
    end

    // lw: 5 cycles
    rstN = 1'b1;
    chk("lw_fetch", E_FETCH);
    nxt("lw_decode", E_DEC);
    nxt("lw_memadr", E_ADR);
    nxt("lw_memrd", E_MEMRD);
    nxt("lw_memwb", E_MEMWB);

    // R-type sub and slt: 4 cycles each
    nxt("sub_fetch", E_FETCH);
    bus.op = 6'b000000; bus.funct = 6'b100010;
    nxt("sub_decode", E_DEC);
    nxt("sub_execute", eExec(3'b110));
    nxt("sub_aluwb", E_ALUWB);
    nxt("slt_fetch", E_FETCH);
    bus.funct = 6'b101010;
    nxt("slt_decode", E_DEC);
    nxt("slt_execute", eExec(3'b111));
    nxt("slt_aluwb", E_ALUWB);

    // addi: 4 cycles
    nxt("addi_fetch", E_FETCH);
    bus.op = 6'b001000;
    nxt("addi_decode", E_DEC);
    nxt("addi_exec", E_ADR);
    nxt("addi_wb", E_ADDIWB);

    // beq taken, then zero dropping within BRANCH lowers pcEn right away
    nxt("beq1_fetch", E_FETCH);
    bus.op = 6'b000100; bus.zero = 1'b1;
    nxt("beq1_decode", E_DEC);
    nxt("beq1_branch_z1", eBranch(1'b1));
    bus.zero = 1'b0;
    chk("beq1_branch_z0", eBranch(1'b0));

    // beq not taken
    nxt("beq2_fetch", E_FETCH);
    nxt("beq2_decode", E_DEC);
    nxt("beq2_branch", eBranch(1'b0));

    // illegal opcode, then an R-type with an unsupported funct
    nxt("ill1_fetch", E_FETCH);
    bus.op = 6'b111111;
    nxt("ill1_decode", E_ILL);
    nxt("ill2_fetch", E_FETCH);
    bus.op = 6'b000000; bus.funct = 6'b000000;
    nxt("ill2_decode", E_ILL);

    // sw aborted by reset in MEMADR
    nxt("sw_fetch", E_FETCH);
    bus.op = 6'b101011;
    nxt("sw_decode", E_DEC);
    nxt("sw_memadr", E_ADR);
    #2 rstN = 1'b0;
    chk("sw_abort", E_RST);
    nxt("sw_abort_hold", E_RST);
    rstN = 1'b1;

    // normal fetch resumes with a j
    chk("j_fetch", E_FETCH);
    bus.op = 6'b000010;
    nxt("j_decode", E_DEC);
    nxt("j_jump", E_JUMP);
    nxt("j_next_fetch", E_FETCH);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
